rx_ip_drop_buffer: RTL and testbench
====================================

# rx_ip_drop_buffer

Receive-path frame store directly downstream of the IP filter. It buffers every byte of an incoming GMAC frame, samples the filter's `match` flag at end of frame, and then commits or discards the whole frame. Committed frames are replayed as a contiguous byte stream with a fixed inter-frame gap toward the rest of the receive path, so a blocked source IP (192.168.1.120) never leaves the block.

## Interface
- `ADDR_W`, 11: log2 of frame-store bytes (2048).
- `LFIFO_W`, 3: log2 of length-FIFO entries (8 committed frames).
- `IFG`, 12: idle cycles inserted between output frames (≥1).
- `rxcoreclk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `gmac_rx_data`  in  8  receive byte, valid when `gmac_rx_dvld`=1.
- `gmac_rx_dvld`  in  1  frame-active strobe, contiguous per frame.
- `match`  in  1  filter verdict, registered output of the IP filter.
- `out_data`  out  8  replayed byte.
- `out_dvld`  out  1  replay strobe, contiguous per frame.
- `pass_cnt`  out  16  frames committed, saturating.
- `drop_cnt`  out  16  frames discarded on `match`, saturating.
- `ovf_cnt`  out  16  frames discarded for lack of space, saturating.

## Operation
- Storage: byte RAM of 2^ADDR_W entries with synchronous read. Pointers `wr_ptr`, `start_ptr`, `rd_ptr` are ADDR_W+1 bits and wrap modulo 2^(ADDR_W+1). used = `wr_ptr`−`rd_ptr`. full when used = 2^ADDR_W.
- Length FIFO: 2^LFIFO_W entries of ADDR_W+1 bits, one entry per committed frame.
- Write FSM:
  - W_IDLE: on `gmac_rx_dvld`=1, write byte at `wr_ptr`, set `start_ptr`←old `wr_ptr`, len←1, clear ovf flag, go to W_FRAME.
  - W_FRAME: while dvld=1, write the byte if not full, else set ovf and stop writing. len increments only on stored bytes.
  - End cycle E is the first cycle in W_FRAME with dvld=0. `match` is sampled in cycle E only; the filter holds `match` through E.
    - ovf, or length FIFO full: `wr_ptr`←`start_ptr`, `ovf_cnt`++.
    - else if `match`=1: `wr_ptr`←`start_ptr`, `drop_cnt`++.
    - else: push len, `pass_cnt`++. Stored bytes stay.
  - Then return to W_IDLE.
  - W_SKIP: entered from reset if dvld=1. Ignores bytes until dvld=0, then goes to W_IDLE.
- Read FSM:
  - R_IDLE: length FIFO not empty → pop the entry, load remaining←len, go to R_READ.
  - R_READ: issue one RAM read per cycle and advance `rd_ptr`. `out_dvld`/`out_data` are registered one cycle after the read. After the last byte, go to R_GAP.
  - R_GAP: count IFG cycles with `out_dvld`=0, then go to R_IDLE.
- Simultaneous events:
  - Push and pop of the length FIFO in the same cycle are both honoured.
  - A read advancing `rd_ptr` in the same cycle as a write uses pre-update used for the full check. This is conservative, and one byte of slack is acceptable.
- Counters saturate at 16'hFFFF.

## Timing
- Reset values:
  - `out_dvld`=0, `out_data`=0, all counters 0.
  - All pointers 0, length FIFO empty.
  - Write FSM goes to W_IDLE, or W_SKIP if dvld=1 in the reset cycle. Read FSM goes to R_IDLE.
- Reset mid-frame: the partial frame is lost without being counted. Any replay in progress is truncated, and `out_dvld` falls the cycle after reset.
- Commit latency: the entry is visible at E+1. With the read side in R_IDLE, pop happens at E+1, the first RAM read at E+2, and the first `out_dvld`=1 at E+3.
- Output frame length equals input length. Bytes are in order and `out_dvld` never gaps mid-frame.
- Between output frames there are exactly IFG idle cycles when frames are queued.
- Minimum input gap is 2 idle cycles. The IP filter needs 1 to clear `match`, which prevents a stale verdict carrying into the next frame's E.

## Test plan
- 64-byte frame, source IP C0 A8 01 79 at bytes 26–29, `match`=0 → identical 64 bytes out starting at E+3, `pass_cnt`=1.
- Same frame with IP C0 A8 01 78 and `match` high from byte 30 through E → no output, `drop_cnt`=1, `wr_ptr` restored to `start_ptr`.
- Three back-to-back 100-byte passing frames with 12-cycle input gaps → three 100-byte bursts out, each separated by exactly IFG=12 idle cycles.
- ADDR_W=8, one 300-byte frame → dropped, `ovf_cnt`=1. A following 60-byte frame passes intact.
- Nine 64-byte passing frames with output held off by a long replay → the ninth is dropped for length-FIFO full (`ovf_cnt`=1) or passes if a pop occurred first. Check against a reference model, including pointer wrap across 2^(ADDR_W+1).
- Assert `reset` at byte 20 of an input frame and mid-replay → `out_dvld`=0 next cycle, counters 0, the rest of the input frame is ignored (W_SKIP), and the next frame passes normally.

Source files
------------

// File: rtl/rx_ip_drop_buffer.sv
// Receive frame store behind the IP filter: buffers each frame, commits or discards
// it on the end-of-frame verdict, and replays committed frames with a fixed gap.
module rx_ip_drop_buffer #(
   parameter int unsigned ADDR_W  = 11,
   parameter int unsigned LFIFO_W = 3,
   parameter int unsigned IFG     = 12
) (
   input  logic        rxcoreclk,
   input  logic        reset,
   input  logic [7:0]  gmac_rx_data,
   input  logic        gmac_rx_dvld,
   input  logic        match,
   output logic [7:0]  out_data,
   output logic        out_dvld,
   output logic [15:0] pass_cnt,
   output logic [15:0] drop_cnt,
   output logic [15:0] ovf_cnt
);
   localparam int unsigned PTR_W  = ADDR_W + 1;
   localparam int unsigned DEPTH  = 2 ** ADDR_W;
   localparam int unsigned LDEPTH = 2 ** LFIFO_W;
   localparam int unsigned LCNT_W = LFIFO_W + 1;
   localparam int unsigned GAP_W  = $clog2(IFG + 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((IFG > 1) ? IFG - 2 : 0);

   localparam logic [1:0] W_IDLE  = 2'd0;
   localparam logic [1:0] W_FRAME = 2'd1;
   localparam logic [1:0] W_SKIP  = 2'd2;
   localparam logic [1:0] R_IDLE  = 2'd0;
   localparam logic [1:0] R_READ  = 2'd1;
   localparam logic [1:0] R_GAP   = 2'd2;

   logic [7:0]        r_mem [DEPTH];
   logic [PTR_W-1:0]  r_lfifo [LDEPTH];
   logic [PTR_W-1:0]  r_wr_ptr, r_start_ptr, r_rd_ptr, r_len, r_remain;
   logic              r_ovf;
   logic [LFIFO_W-1:0] r_lwp, r_lrp;
   logic [LCNT_W-1:0] r_lcnt;
   logic [1:0]        r_wstate, w_wstate_nx, r_rstate, w_rstate_nx;
   logic [GAP_W-1:0]  r_gap;
   logic              w_full, w_lfifo_full, w_wr_en, w_start, w_end, w_push;
   logic              w_pop, w_rd_en, w_last;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Full check uses pre-update pointers; a same-cycle read only frees space later.
   assign w_full       = (r_wr_ptr - r_rd_ptr) == PTR_W'(DEPTH);
   assign w_lfifo_full = r_lcnt == LCNT_W'(LDEPTH);
   assign w_push       = w_end && !r_ovf && !w_lfifo_full && !match;
   assign w_last       = r_remain == PTR_W'(1);

   always_comb begin
      w_wstate_nx = r_wstate;
      w_wr_en     = 1'b0;
      w_start     = 1'b0;
      w_end       = 1'b0;
      case (r_wstate)
         W_IDLE: begin
            if (gmac_rx_dvld) begin
               w_start     = 1'b1;
               w_wr_en     = !w_full;
               w_wstate_nx = W_FRAME;
            end
         end
         W_FRAME: begin
            if (gmac_rx_dvld) begin
               w_wr_en = !w_full && !r_ovf;
            end else begin
               w_end       = 1'b1;
               w_wstate_nx = W_IDLE;
            end
         end
         W_SKIP: begin
            if (!gmac_rx_dvld) w_wstate_nx = W_IDLE;
         end
         default: w_wstate_nx = W_IDLE;
      endcase
   end

   // A frame already in flight at reset is skipped rather than stored partially.
   always_ff @(posedge rxcoreclk) begin
      if (reset) r_wstate <= gmac_rx_dvld ? W_SKIP : W_IDLE;
      else       r_wstate <= w_wstate_nx;
   end

   always_ff @(posedge rxcoreclk) begin
      if (w_wr_en && !reset) r_mem[r_wr_ptr[ADDR_W-1:0]] <= gmac_rx_data;
   end

   always_ff @(posedge rxcoreclk) begin
      if (reset) begin
         r_wr_ptr    <= '0;
         r_start_ptr <= '0;
         r_len       <= '0;
         r_ovf       <= 1'b0;
         pass_cnt    <= '0;
         drop_cnt    <= '0;
         ovf_cnt     <= '0;
      end else begin
         if (w_end && !w_push) r_wr_ptr <= r_start_ptr;
         else if (w_wr_en)     r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_start) begin
            r_start_ptr <= r_wr_ptr;
            r_len       <= PTR_W'(w_wr_en);
            r_ovf       <= ~w_wr_en;
         end else if (r_wstate == W_FRAME && gmac_rx_dvld) begin
            if (w_wr_en) r_len <= r_len + PTR_W'(1);
            else         r_ovf <= 1'b1;
         end
         if (w_end) begin
            if (r_ovf || w_lfifo_full) ovf_cnt  <= sat_inc(ovf_cnt);
            else if (match)            drop_cnt <= sat_inc(drop_cnt);
            else                       pass_cnt <= sat_inc(pass_cnt);
         end
      end
   end

   always_ff @(posedge rxcoreclk) begin
      if (w_push && !reset) r_lfifo[r_lwp] <= r_len;
   end

   always_ff @(posedge rxcoreclk) begin
      if (reset) begin
         r_lwp  <= '0;
         r_lrp  <= '0;
         r_lcnt <= '0;
      end else begin
         if (w_push) r_lwp <= r_lwp + LFIFO_W'(1);
         if (w_pop)  r_lrp <= r_lrp + LFIFO_W'(1);
         if (w_push && !w_pop)      r_lcnt <= r_lcnt + LCNT_W'(1);
         else if (!w_push && w_pop) r_lcnt <= r_lcnt - LCNT_W'(1);
      end
   end

   always_comb begin
      w_rstate_nx = r_rstate;
      w_pop       = 1'b0;
      w_rd_en     = 1'b0;
      case (r_rstate)
         R_IDLE: begin
            if (r_lcnt != '0) begin
               w_pop       = 1'b1;
               w_rstate_nx = R_READ;
            end
         end
         R_READ: begin
            w_rd_en = 1'b1;
            if (w_last) w_rstate_nx = (IFG > 1) ? R_GAP : R_IDLE;
         end
         R_GAP: begin
            if (r_gap == '0) w_rstate_nx = R_IDLE;
         end
         default: w_rstate_nx = R_IDLE;
      endcase
   end

   always_ff @(posedge rxcoreclk) begin
      if (reset) r_rstate <= R_IDLE;
      else       r_rstate <= w_rstate_nx;
   end

   // R_GAP lasts IFG-1 cycles; the R_IDLE pop cycle supplies the last idle output cycle.
   always_ff @(posedge rxcoreclk) begin
      if (reset) begin
         r_rd_ptr <= '0;
         r_remain <= '0;
         r_gap    <= '0;
         out_dvld <= 1'b0;
         out_data <= '0;
      end else begin
         out_dvld <= w_rd_en;
         if (w_pop)        r_remain <= r_lfifo[r_lrp];
         else if (w_rd_en) r_remain <= r_remain - PTR_W'(1);
         if (w_rd_en) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            out_data <= r_mem[r_rd_ptr[ADDR_W-1:0]];
         end
         if (w_rd_en && w_last)                   r_gap <= GAP_LOAD;
         else if (r_rstate == R_GAP && r_gap != '0) r_gap <= r_gap - GAP_W'(1);
      end
   end

endmodule

// File: tb/tb_rx_ip_drop_buffer.sv
// Directed bench for rx_ip_drop_buffer: pass, drop, queued replay spacing,
// store overflow, length-FIFO overflow with pointer wrap, and mid-frame reset.
module tb_rx_ip_drop_buffer;
   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  din, din8, od, od8;
   logic        dv, dv8, m, m8, ov, ov8;
   logic [15:0] pc, dc, oc, pc8, dc8, oc8;

   always #5 clk = ~clk;

   rx_ip_drop_buffer #(.ADDR_W(11), .LFIFO_W(3), .IFG(12)) dut (
      .rxcoreclk(clk), .reset(reset), .gmac_rx_data(din), .gmac_rx_dvld(dv),
      .match(m), .out_data(od), .out_dvld(ov),
      .pass_cnt(pc), .drop_cnt(dc), .ovf_cnt(oc));

   rx_ip_drop_buffer #(.ADDR_W(8), .LFIFO_W(3), .IFG(12)) dut8 (
      .rxcoreclk(clk), .reset(reset), .gmac_rx_data(din8), .gmac_rx_dvld(dv8),
      .match(m8), .out_data(od8), .out_dvld(ov8),
      .pass_cnt(pc8), .drop_cnt(dc8), .ovf_cnt(oc8));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: burst boundaries (cycle numbers) and byte streams
   logic       prev_ov = 1'b0, prev_ov8 = 1'b0;
   int         bstart[$], bend[$], b8start[$], b8end[$];
   logic [7:0] obs_q[$], obs8_q[$], exp_q[$], exp8_q[$], frm[$];

   always @(negedge clk) begin
      if (ov) begin
         obs_q.push_back(od);
         if (!prev_ov) bstart.push_back(cyc);
      end else if (prev_ov) bend.push_back(cyc - 1);
      if (ov8) begin
         obs8_q.push_back(od8);
         if (!prev_ov8) b8start.push_back(cyc);
      end else if (prev_ov8) b8end.push_back(cyc - 1);
      prev_ov  <= ov;
      prev_ov8 <= ov8;
   end

   int n_asrt = 0, n_fail = 0;

   task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task step;
      @(posedge clk);
      #1;
   endtask

   // One frame, then E cycle (match held), then one idle cycle with match cleared.
   task send(input bit sel, input int len, input int seed, input int ip_last,
             input int mfrom, output int e);
      logic [7:0] b;
      frm.delete();
      for (int i = 0; i < len; i++) begin
         b = 8'(i * 7 + seed * 13 + 1);
         if (ip_last >= 0) begin
            if (i == 26) b = 8'hC0;
            if (i == 27) b = 8'hA8;
            if (i == 28) b = 8'h01;
            if (i == 29) b = 8'(ip_last);
         end
         frm.push_back(b);
         if (sel) begin din8 = b; dv8 = 1'b1; end
         else begin din = b; dv = 1'b1; m = (mfrom >= 0) && (i >= mfrom); end
         step;
      end
      if (sel) begin dv8 = 1'b0; din8 = '0; end
      else begin dv = 1'b0; din = '0; end
      e = cyc;
      step;
      m = 1'b0;
      m8 = 1'b0;
      step;
   endtask

   task wait_done(input int n, input int budget);
      int b;
      b = budget;
      while (bend.size() < n && b > 0) begin step; b--; end
      chk("burst_timeout", bend.size(), n);
   endtask

   task check_stream(input string tag);
      int bad;
      bad = 0;
      chk({tag, "_bytes"}, obs_q.size(), exp_q.size());
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
         if (obs_q[i] !== exp_q[i]) bad++;
      chk({tag, "_data_errs"}, bad, 0);
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "simulation time limit");
   end

   initial begin : stim
      int e, e0, nb, nbs, bad, bud;
      int e3[3];
      reset = 1'b1; din = '0; dv = 1'b0; m = 1'b0; din8 = '0; dv8 = 1'b0; m8 = 1'b0;
      repeat (3) step;
      reset = 1'b0;
      step;
      chk("rst_out_dvld", ov, 0);
      chk("rst_out_data", od, 0);
      chk("rst_pass", pc, 0);
      chk("rst_drop", dc, 0);
      chk("rst_ovf", oc, 0);
      chk("rst_wr_ptr", dut.r_wr_ptr, 0);

      // 64-byte passing frame, source IP .121
      send(0, 64, 1, 8'h79, -1, e);
      exp_q = frm;
      wait_done(1, 200);
      chk("t1_start", bstart[0], e + 3);
      chk("t1_len", bend[0] - bstart[0] + 1, 64);
      check_stream("t1");
      chk("t1_pass", pc, 1);

      // blocked IP .120, match from byte 30 through E
      send(0, 64, 2, 8'h78, 30, e);
      repeat (30) step;
      chk("t2_drop", dc, 1);
      chk("t2_pass", pc, 1);
      chk("t2_no_out", bstart.size(), 1);
      chk("t2_wr_ptr", dut.r_wr_ptr, 64);

      // three 100-byte frames, 12 idle cycles between inputs
      nb = bend.size();
      for (int k = 0; k < 3; k++) begin
         send(0, 100, 10 + k, -1, -1, e3[k]);
         foreach (frm[i]) exp_q.push_back(frm[i]);
         repeat (10) step;
      end
      wait_done(nb + 3, 600);
      chk("t3_start", bstart[nb], e3[0] + 3);
      for (int k = 0; k < 3; k++) begin
         chk("t3_len", bend[nb + k] - bstart[nb + k] + 1, 100);
         if (k > 0) chk("t3_gap", bstart[nb + k] - bend[nb + k - 1] - 1, 12);
      end
      check_stream("t3");
      chk("t3_pass", pc, 4);

      // small store: 300-byte frame overflows, 60-byte frame then passes
      send(1, 300, 20, -1, -1, e);
      repeat (20) step;
      chk("t4_ovf", oc8, 1);
      chk("t4_pass0", pc8, 0);
      chk("t4_drop", dc8, 0);
      chk("t4_no_out", b8start.size(), 0);
      send(1, 60, 21, -1, -1, e);
      exp8_q = frm;
      bud = 200;
      while (b8end.size() < 1 && bud > 0) begin step; bud--; end
      chk("t4_done", b8end.size(), 1);
      chk("t4_start", b8start[0], e + 3);
      chk("t4_bytes", obs8_q.size(), 60);
      bad = 0;
      for (int i = 0; i < obs8_q.size() && i < exp8_q.size(); i++)
         if (obs8_q[i] !== exp8_q[i]) bad++;
      chk("t4_data_errs", bad, 0);
      chk("t4_pass1", pc8, 1);

      // long replay holds off reads; ninth queued frame finds the length FIFO full
      nb = bend.size();
      send(0, 2000, 30, -1, -1, e0);
      foreach (frm[i]) exp_q.push_back(frm[i]);
      for (int k = 1; k <= 9; k++) begin
         send(0, 64, 30 + k, -1, -1, e);
         if (k <= 8) foreach (frm[i]) exp_q.push_back(frm[i]);
      end
      chk("t5_ovf", oc, 1);
      chk("t5_pass", pc, 13);
      wait_done(nb + 9, 4000);
      repeat (50) step;
      chk("t5_bursts", bstart.size(), nb + 9);
      chk("t5_start", bstart[nb], e0 + 3);
      chk("t5_len_long", bend[nb] - bstart[nb] + 1, 2000);
      for (int k = 1; k < 9; k++) begin
         chk("t5_len", bend[nb + k] - bstart[nb + k] + 1, 64);
         chk("t5_gap", bstart[nb + k] - bend[nb + k - 1] - 1, 12);
      end
      check_stream("t5");

      // 1300-byte frame carries the pointers across 4096
      nb = bend.size();
      send(0, 1300, 50, -1, -1, e);
      exp_q = frm;
      wait_done(nb + 1, 2000);
      chk("t6_start", bstart[nb], e + 3);
      chk("t6_len", bend[nb] - bstart[nb] + 1, 1300);
      check_stream("t6");
      chk("t6_pass", pc, 14);
      chk("t6_wr_ptr", dut.r_wr_ptr, 80);
      chk("t6_rd_ptr", dut.r_rd_ptr, 80);

      // reset at byte 20 of an input frame while another frame is replaying
      send(0, 200, 60, -1, -1, e);
      for (int i = 0; i < 100; i++) begin
         din = 8'(i * 3 + 5);
         dv = 1'b1;
         if (i == 20) begin
            chk("t7_replay_active", ov, 1);
            reset = 1'b1;
         end
         step;
         if (i == 20) begin
            reset = 1'b0;
            chk("t7_out_dvld", ov, 0);
            chk("t7_pass", pc, 0);
            chk("t7_drop", dc, 0);
            chk("t7_ovf", oc, 0);
         end
      end
      dv = 1'b0;
      din = '0;
      nbs = bstart.size();
      obs_q.delete();
      exp_q.delete();
      repeat (20) step;
      chk("t7_skip_pass", pc, 0);
      chk("t7_skip_no_out", bstart.size(), nbs);
      chk("t7_skip_wr_ptr", dut.r_wr_ptr, 0);
      nb = bend.size();
      send(0, 64, 70, 8'h79, -1, e);
      exp_q = frm;
      wait_done(nb + 1, 200);
      chk("t7_start", bstart[nb], e + 3);
      chk("t7_len", bend[nb] - bstart[nb] + 1, 64);
      check_stream("t7");
      chk("t7_pass_after", pc, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
